// File: rtl/mux8_scan_sequencer.sv
// mux8_scan_sequencer: walks an external 8:1 mux through channels 0..7,
// holds each select for a programmable settle time, samples the mux output
// and presents the eight samples as one word with a single-cycle valid.
module mux8_scan_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    input  logic       mux_y,
    output logic [2:0] sel,
    output logic       busy,
    output logic       valid,
    output logic [7:0] data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Terminal settle count: SETTLE spans counts 0..SETTLE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       sel_nxt;
    logic             busy_nxt;
    logic             valid_nxt;
    logic [7:0]       data_nxt;

    // State and all registered outputs; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= 3'd0;
            busy  <= 1'b0;
            valid <= 1'b0;
            data  <= 8'h00;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sel   <= sel_nxt;
            busy  <= busy_nxt;
            valid <= valid_nxt;
            data  <= data_nxt;
        end
    end

    // Next-state and next-output logic; abort overrides every other path.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        busy_nxt  = busy;
        valid_nxt = 1'b0;
        data_nxt  = data;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETTLE;
                    sel_nxt   = 3'd0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            SETTLE: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                // sel is stable here; it only moves on the edge leaving SAMPLE.
                data_nxt[sel] = mux_y;
                if (sel != 3'd7) begin
                    sel_nxt   = sel + 3'd1;
                    cnt_nxt   = '0;
                    state_nxt = SETTLE;
                end else begin
                    state_nxt = DONE;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            DONE: begin
                if (cont) begin
                    state_nxt = SETTLE;
                    sel_nxt   = 3'd0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        // Abort drops the scan; bits already captured are left in data.
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
            sel_nxt   = 3'd0;
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
            valid_nxt = 1'b0;
            data_nxt  = data;
        end else if (abort) begin
            state_nxt = IDLE;
            sel_nxt   = sel;
            cnt_nxt   = cnt;
            busy_nxt  = busy;
        end
    end

endmodule

// File: tb/tb_mux8_scan_sequencer.sv
// Bench for mux8_scan_sequencer: two instances (settle 2 and settle 1),
// behavioural mux models and a queue of expected words per instance.
module tb_mux8_scan_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, cont, abort, mux_y;
    logic [2:0] sel;
    logic       busy, valid;
    logic [7:0] data, pat;

    logic       rst1_n, start1, cont1, abort1, mux_y1;
    logic [2:0] sel1;
    logic       busy1, valid1;
    logic [7:0] data1, pat1;

    assign mux_y  = pat[sel];
    assign mux_y1 = pat1[sel1];

    mux8_scan_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .mux_y(mux_y), .sel(sel), .busy(busy), .valid(valid), .data(data)
    );

    mux8_scan_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst1_n), .start(start1), .cont(cont1), .abort(abort1),
        .mux_y(mux_y1), .sel(sel1), .busy(busy1), .valid(valid1), .data(data1)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         vcnt [2];
    int         vcyc [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Free-running cycle counter for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors: each valid pulse pops and compares one expected word.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vcnt[0] = vcnt[0] + 1;
            vcyc[0] = cyc;
            if (q0.size() == 0) check("valid0_unexpected", 32'(valid), 32'd0);
            else begin
                check("data0", 32'(data), 32'(q0.pop_front()));
                check("busy0_in_done", 32'(busy), 32'd0);
            end
        end
        if (valid1 === 1'b1) begin
            vcnt[1] = vcnt[1] + 1;
            vcyc[1] = cyc;
            if (q1.size() == 0) check("valid1_unexpected", 32'(valid1), 32'd0);
            else check("data1", 32'(data1), 32'(q1.pop_front()));
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_scan(input int i, output int c);
        if (i == 0) start = 1'b1;
        else        start1 = 1'b1;
        @(posedge clk);
        #1;
        c = cyc;
        start  = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_valid(input int i, input int old, input int start_c,
                              input int lat, input string tag);
        int n;
        n = 0;
        while (vcnt[i] == old && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_seen"}, 32'(vcnt[i] - old), 32'd1);
        if (vcnt[i] != old) check({tag, "_latency"}, 32'(vcyc[i] - start_c), 32'(lat));
    endtask

    initial begin
        int c, old, first;
        vcnt[0] = 0; vcnt[1] = 0; vcyc[0] = 0; vcyc[1] = 0;
        rst_n = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; pat = 8'h00;
        rst1_n = 1'b1; start1 = 1'b0; cont1 = 1'b0; abort1 = 1'b0; pat1 = 8'h00;

        // Reset asserted mid-cycle takes effect immediately.
        cycles(2);
        #3;
        rst_n = 1'b0;
        rst1_n = 1'b0;
        #1;
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data", 32'(data), 32'h00);
        check("rst_data1", 32'(data1), 32'h00);
        cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        rst1_n = 1'b1;
        cycles(10);
        check("idle_sel", 32'(sel), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_data", 32'(data), 32'h00);
        check("idle_nvalid", 32'(vcnt[0]), 32'd0);

        // Abort together with start in IDLE: start is ignored.
        start = 1'b1;
        abort = 1'b1;
        cycles(1);
        start = 1'b0;
        abort = 1'b0;
        check("idle_abort_busy", 32'(busy), 32'd0);

        // Single scan, pattern A5, select trace checked every cycle.
        pat = 8'hA5;
        q0.push_back(8'hA5);
        old = vcnt[0];
        start_scan(0, c);
        check("scan_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 24; k++) begin
            check("scan_sel", 32'(sel), 32'(k / 3));
            cycles(1);
        end
        wait_valid(0, old, c, 24, "scan");
        cycles(3);
        check("scan_npulse", 32'(vcnt[0] - old), 32'd1);
        check("scan_busy_end", 32'(busy), 32'd0);

        // Continuous mode: 3C then C3, pulses 25 cycles apart.
        pat = 8'h3C;
        cont = 1'b1;
        q0.push_back(8'h3C);
        old = vcnt[0];
        start_scan(0, c);
        wait_valid(0, old, c, 24, "cont1");
        pat = 8'hC3;
        q0.push_back(8'hC3);
        first = vcyc[0];
        old = vcnt[0];
        for (int k = 1; k <= 25; k++) begin
            cycles(1);
            check("cont_busy", 32'(busy), 32'(k != 25));
        end
        cont = 1'b0;
        wait_valid(0, old, first, 25, "cont2");
        cycles(3);
        check("cont_busy_end", 32'(busy), 32'd0);

        // Second start while busy is ignored.
        pat = 8'h96;
        q0.push_back(8'h96);
        old = vcnt[0];
        start_scan(0, c);
        cycles(12);
        check("ign_sel", 32'(sel), 32'd4);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        wait_valid(0, old, c, 24, "ign");
        cycles(30);
        check("ign_npulse", 32'(vcnt[0] - old), 32'd1);

        // Abort at sel 3 keeps captured bits and produces no valid.
        pat = 8'h5A;
        old = vcnt[0];
        start_scan(0, c);
        cycles(9);
        check("abort_sel_before", 32'(sel), 32'd3);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sel", 32'(sel), 32'd0);
        check("abort_data", 32'(data), 32'h92);
        cycles(30);
        check("abort_npulse", 32'(vcnt[0] - old), 32'd0);
        pat = 8'hE7;
        q0.push_back(8'hE7);
        old = vcnt[0];
        start_scan(0, c);
        wait_valid(0, old, c, 24, "post_abort");

        // Settle of one cycle: 16-cycle scan, then reset at sel 6.
        pat1 = 8'hFF;
        q1.push_back(8'hFF);
        old = vcnt[1];
        start_scan(1, c);
        wait_valid(1, old, c, 16, "s1");
        cycles(2);
        old = vcnt[1];
        start_scan(1, c);
        cycles(12);
        check("s1_sel_before", 32'(sel1), 32'd6);
        rst1_n = 1'b0;
        #1;
        check("s1_rst_data", 32'(data1), 32'h00);
        check("s1_rst_busy", 32'(busy1), 32'd0);
        check("s1_rst_sel", 32'(sel1), 32'd0);
        @(negedge clk);
        rst1_n = 1'b1;
        cycles(30);
        check("s1_rst_npulse", 32'(vcnt[1] - old), 32'd0);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
